// File: rtl/dkong_snd_pkg.sv
// Shared types and default constants for the Donkey Kong sound ROM arbiter.
package dkong_snd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_WAV = 1'b1
  } grant_t;

  localparam int unsigned DEF_ROM_LATENCY = 2;
  localparam logic [19:0] DEF_CPU_BASE    = 20'h80000;
  localparam int unsigned DEF_STARVE_MAX  = 8;

  // 8035 program addresses are relocated into the unified ROM, wrapping at 1 MiB.
  function automatic logic [19:0] cpu_rom_addr(input logic [19:0] base, input logic [11:0] a);
    return base + {8'h00, a};
  endfunction

endpackage

// File: rtl/dkong_snd_rom_arbiter_if.sv
// Requester and ROM-side signals of the sound ROM arbiter; master is the arbiter side.
interface dkong_snd_rom_arbiter_if;

  logic        CPU_REQ;
  logic [11:0] CPU_A;
  logic [7:0]  CPU_D;
  logic        CPU_ACK;
  logic        WAV_REQ;
  logic [18:0] WAV_A;
  logic [7:0]  WAV_D;
  logic        WAV_ACK;
  logic [19:0] MEM_A;
  logic        MEM_RD;
  logic [7:0]  MEM_D;
  logic        BUSY;

  modport master (
    input  CPU_REQ, CPU_A, WAV_REQ, WAV_A, MEM_D,
    output CPU_D, CPU_ACK, WAV_D, WAV_ACK, MEM_A, MEM_RD, BUSY
  );

  modport slave (
    output CPU_REQ, CPU_A, WAV_REQ, WAV_A, MEM_D,
    input  CPU_D, CPU_ACK, WAV_D, WAV_ACK, MEM_A, MEM_RD, BUSY
  );

endinterface

// File: rtl/dkong_snd_arb_pick.sv
// Grant selection: strict CPU priority, overridden for WAV when the requester is starved.
module dkong_snd_arb_pick
  import dkong_snd_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   wav_req_i,
  input  logic   starved_i,
  output logic   gnt_valid_o,
  output grant_t gnt_o
);

  always_comb begin
    gnt_valid_o = cpu_req_i | wav_req_i;
    gnt_o       = GNT_CPU;
    if (wav_req_i && (starved_i || !cpu_req_i)) begin
      gnt_o = GNT_WAV;
    end
  end

endmodule

// File: rtl/dkong_snd_rom_arbiter.sv
// Shares one sound ROM between the 8035 program fetch and the wav sample reader.
// Optional starvation guard for the wav side: define DKSND_ARB_STARVE_GUARD_EN.
module dkong_snd_rom_arbiter
  import dkong_snd_pkg::*;
#(
  parameter int unsigned ROM_LATENCY = DEF_ROM_LATENCY,
  parameter logic [19:0] CPU_BASE    = DEF_CPU_BASE,
  parameter int unsigned STARVE_MAX  = DEF_STARVE_MAX
) (
  input  logic                   W_CLK_24576M,
  input  logic                   W_RESETn,
  dkong_snd_rom_arbiter_if.master bus
);

  if (ROM_LATENCY < 1 || ROM_LATENCY > 7) begin : g_bad_latency
    $error("ROM_LATENCY must be in 1..7");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

  localparam logic [2:0] LAT = 3'(ROM_LATENCY);

  arb_state_t  state_q, state_d;
  grant_t      gnt_q, gnt_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] mem_a_q, mem_a_d;
  logic        mem_rd_q, mem_rd_d;
  logic [7:0]  cpu_d_q, cpu_d_d;
  logic [7:0]  wav_d_q, wav_d_d;

  logic   pick_valid;
  grant_t pick_gnt;
  logic   starved;

  dkong_snd_arb_pick u_pick (
    .cpu_req_i  (bus.CPU_REQ),
    .wav_req_i  (bus.WAV_REQ),
    .starved_i  (starved),
    .gnt_valid_o(pick_valid),
    .gnt_o      (pick_gnt)
  );

`ifdef DKSND_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  // Counts CPU wins over a waiting wav request; any wav grant forgives the debt.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && pick_valid) begin
      if (pick_gnt == GNT_WAV) begin
        starve_d = '0;
      end else if (bus.WAV_REQ && starve_q != STARVE_LIM) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign starved = (starve_q == STARVE_LIM);
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    mem_a_d  = mem_a_q;
    mem_rd_d = 1'b0;
    cpu_d_d  = cpu_d_q;
    wav_d_d  = wav_d_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d    = pick_gnt;
          mem_a_d  = (pick_gnt == GNT_CPU) ? cpu_rom_addr(CPU_BASE, bus.CPU_A)
                                           : {1'b0, bus.WAV_A};
          mem_rd_d = 1'b1;
          cnt_d    = 3'd0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // cnt_q == 0 is the MEM_RD cycle, so data is valid when cnt_q reaches LAT.
        if (cnt_q == LAT) begin
          if (gnt_q == GNT_CPU) begin
            cpu_d_d = bus.MEM_D;
          end else begin
            wav_d_d = bus.MEM_D;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_CPU;
      cnt_q    <= 3'd0;
      mem_a_q  <= 20'h00000;
      mem_rd_q <= 1'b0;
      cpu_d_q  <= 8'h00;
      wav_d_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      mem_a_q  <= mem_a_d;
      mem_rd_q <= mem_rd_d;
      cpu_d_q  <= cpu_d_d;
      wav_d_q  <= wav_d_d;
    end
  end

  assign bus.MEM_A   = mem_a_q;
  assign bus.MEM_RD  = mem_rd_q;
  assign bus.CPU_D   = cpu_d_q;
  assign bus.WAV_D   = wav_d_q;
  assign bus.CPU_ACK = (state_q == DONE) && (gnt_q == GNT_CPU);
  assign bus.WAV_ACK = (state_q == DONE) && (gnt_q == GNT_WAV);
  assign bus.BUSY    = (state_q != IDLE);

endmodule
